// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register file write-port arbiter for pipeline and multdiv results
//
// The pipeline writeback always owns the write port. Multdiv results queue in a
// small FIFO and drain into cycles where the pipeline does not write. A pending
// scoreboard tracks the destinations of issued multdiv operations so that decode
// can stall on RAW hazards.
//
// Ports:
//   clock, ctrl_reset                     clock, asynchronous active-high reset
//   pipe_valid, pipe_rd, pipe_data        pipeline writeback result
//   md_issue, md_issue_rd                 multdiv launch (sets pending bit)
//   md_valid, md_rd, md_data, md_ready    multdiv result handshake into the FIFO
//   query_a/b, busy_a/b                   decode hazard queries
//   err_overflow                          sticky: result arrived while FIFO full
//   ctrl_writeEnable, ctrl_writeReg,
//   data_writeReg                         registered register file write port
module wb_port_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        md_issue,
  input  logic [4:0]  md_issue_rd,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        md_ready,
  input  logic [4:0]  query_a,
  input  logic [4:0]  query_b,
  output logic        busy_a,
  output logic        busy_b,
  output logic        err_overflow,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [4:0]    fifo_rd_q   [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          we_q, we_d;
  logic [4:0]    wreg_q, wreg_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   pending_q, pending_d;
  logic          err_q, err_d;

  logic          fifo_full, fifo_empty;
  logic          pipe_take, fifo_pop, fifo_push;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

  always_comb begin
    fifo_full  = (count_q == FULL_CNT);
    fifo_empty = (count_q == '0);
    head_rd    = fifo_rd_q[rd_ptr_q];
    head_data  = fifo_data_q[rd_ptr_q];

    // A pipeline write to r0 is treated as an idle slot the FIFO may use.
    pipe_take = pipe_valid && (pipe_rd != 5'd0);
    fifo_pop  = !pipe_take && !fifo_empty;
    // Readiness comes from start-of-cycle occupancy; a same-cycle pop does
    // not make room for a push.
    fifo_push = md_valid && !fifo_full && (md_rd != 5'd0);

    wr_ptr_d = fifo_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = fifo_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (fifo_push && !fifo_pop) begin
      count_d = count_q + CW'(1);
    end else if (!fifo_push && fifo_pop) begin
      count_d = count_q - CW'(1);
    end

    // Address and data hold their last values when no write is issued.
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (pipe_take) begin
      we_d    = 1'b1;
      wreg_d  = pipe_rd;
      wdata_d = pipe_data;
    end else if (fifo_pop) begin
      we_d    = 1'b1;
      wreg_d  = head_rd;
      wdata_d = head_data;
    end

    // Clear first so that a same-cycle issue to the same register wins.
    pending_d = pending_q;
    if (fifo_pop) begin
      pending_d[head_rd] = 1'b0;
    end
    if (md_issue && (md_issue_rd != 5'd0)) begin
      pending_d[md_issue_rd] = 1'b1;
    end

    err_d = err_q | (md_valid & fifo_full);
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      we_q      <= 1'b0;
      wreg_q    <= '0;
      wdata_q   <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      we_q      <= we_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clock) begin
    if (fifo_push) begin
      fifo_rd_q[wr_ptr_q]   <= md_rd;
      fifo_data_q[wr_ptr_q] <= md_data;
    end
  end

  assign md_ready         = !fifo_full;
  assign busy_a           = (query_a != 5'd0) && pending_q[query_a];
  assign busy_b           = (query_b != 5'd0) && pending_q[query_b];
  assign err_overflow     = err_q;
  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - scoreboard testbench for wb_port_arbiter
module tb_wb_port_arbiter;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b1;
  logic        pipe_valid = 1'b0;
  logic [4:0]  pipe_rd = '0;
  logic [31:0] pipe_data = '0;
  logic        md_issue = 1'b0;
  logic [4:0]  md_issue_rd = '0;
  logic        md_valid = 1'b0;
  logic [4:0]  md_rd = '0;
  logic [31:0] md_data = '0;
  logic        md_ready;
  logic [4:0]  query_a = '0;
  logic [4:0]  query_b = '0;
  logic        busy_a, busy_b, err_overflow;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  wb_port_arbiter #(.DEPTH(DEPTH)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .md_issue(md_issue), .md_issue_rd(md_issue_rd),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
    .query_a(query_a), .query_b(query_b), .busy_a(busy_a), .busy_b(busy_b),
    .err_overflow(err_overflow),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          at_edge;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  int          n_vec = 0;
  int          n_bad = 0;
  int          edge_cnt = 0;
  exp_t        expq[$];
  ent_t        mq[$];
  logic [31:0] pend = '0;
  logic        err_m = 1'b0;
  logic [4:0]  last_rd = '0;
  logic [31:0] last_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // One cycle of stimulus: drive after the falling edge, check the
  // combinational outputs against the model's start-of-cycle state, then
  // advance the model by the arbitration rules.
  task automatic step(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                      input logic mi, input logic [4:0] mird,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                      input logic [4:0] qa, input logic [4:0] qb);
    exp_t x;
    ent_t e;
    bit   was_full;
    @(negedge clock);
    pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
    md_issue = mi; md_issue_rd = mird;
    md_valid = mv; md_rd = mrd; md_data = md;
    query_a = qa; query_b = qb;
    #1;
    chk("md_ready", {31'd0, md_ready}, (mq.size() < DEPTH) ? 32'd1 : 32'd0);
    chk("busy_a", {31'd0, busy_a}, (qa != 0 && pend[qa]) ? 32'd1 : 32'd0);
    chk("busy_b", {31'd0, busy_b}, (qb != 0 && pend[qb]) ? 32'd1 : 32'd0);
    chk("err_overflow", {31'd0, err_overflow}, {31'd0, err_m});
    was_full = (mq.size() == DEPTH);
    x.at_edge = edge_cnt + 1;
    if (pv && prd != 0) begin
      x.rd = prd; x.data = pd;
      expq.push_back(x);
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      x.rd = e.rd; x.data = e.data;
      expq.push_back(x);
      pend[e.rd] = 1'b0;
    end
    if (mv) begin
      if (was_full) err_m = 1'b1;
      else if (mrd != 0) begin
        e.rd = mrd; e.data = md;
        mq.push_back(e);
      end
    end
    if (mi && mird != 0) pend[mird] = 1'b1;
  endtask

  task automatic idle(input int n, input logic [4:0] qa, input logic [4:0] qb);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, qa, qb);
  endtask

  task automatic do_reset(input logic [4:0] qa, input logic [4:0] qb);
    @(negedge clock);
    ctrl_reset = 1'b1;
    pipe_valid = 0; md_issue = 0; md_valid = 0;
    query_a = qa; query_b = qb;
    mq.delete(); expq.delete(); pend = '0; err_m = 1'b0;
    #1;
    chk("rst_we", {31'd0, ctrl_writeEnable}, 32'd0);
    chk("rst_wreg", {27'd0, ctrl_writeReg}, 32'd0);
    chk("rst_wdata", data_writeReg, 32'd0);
    chk("rst_md_ready", {31'd0, md_ready}, 32'd1);
    chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
    chk("rst_busy_b", {31'd0, busy_b}, 32'd0);
    chk("rst_err", {31'd0, err_overflow}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    ctrl_reset = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever a write is due and checks that no
  // unexpected write appears and that address/data hold when idle.
  initial begin
    exp_t x;
    forever begin
      @(posedge clock);
      edge_cnt++;
      #2;
      if (ctrl_reset) begin
        chk("reset_we", {31'd0, ctrl_writeEnable}, 32'd0);
        chk("reset_wreg", {27'd0, ctrl_writeReg}, 32'd0);
        chk("reset_wdata", data_writeReg, 32'd0);
        last_rd = '0; last_data = '0;
      end else if (expq.size() > 0 && expq[0].at_edge == edge_cnt) begin
        x = expq.pop_front();
        chk("write_en", {31'd0, ctrl_writeEnable}, 32'd1);
        chk("write_reg", {27'd0, ctrl_writeReg}, {27'd0, x.rd});
        chk("write_data", data_writeReg, x.data);
        last_rd = x.rd; last_data = x.data;
      end else begin
        chk("idle_we", {31'd0, ctrl_writeEnable}, 32'd0);
        chk("hold_reg", {27'd0, ctrl_writeReg}, {27'd0, last_rd});
        chk("hold_data", data_writeReg, last_data);
      end
    end
  end

  initial begin
    // Reset state, then release.
    do_reset(5'd7, 5'd9);
    idle(2, 0, 0);

    // Pipeline only, including an r0 write that must not reach the port.
    step(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 32'h9999, 0, 0, 0, 0, 0, 0, 0);
    idle(2, 0, 0);

    // Multdiv into an idle port.
    step(0, 0, 0, 1, 7, 0, 0, 0, 7, 0);
    idle(2, 7, 0);
    step(0, 0, 0, 0, 0, 1, 7, 32'hDEAD, 7, 0);
    idle(3, 7, 0);

    // Contention: pipeline writes every cycle while r8/r9 results queue.
    step(1, 1, 32'hA1, 1, 8, 0, 0, 0, 8, 9);
    step(1, 2, 32'hA2, 1, 9, 1, 8, 32'd1, 8, 9);
    step(1, 3, 32'hA3, 0, 0, 1, 9, 32'd2, 8, 9);
    step(1, 4, 32'hA4, 0, 0, 0, 0, 0, 8, 9);
    idle(3, 8, 9);

    // Overflow: fill, push once more while full, then watch it stay set.
    step(1, 1, 32'hB1, 0, 0, 1, 10, 32'h10, 10, 11);
    step(1, 2, 32'hB2, 0, 0, 1, 11, 32'h11, 10, 11);
    step(1, 3, 32'hB3, 0, 0, 1, 12, 32'h12, 12, 0);
    idle(5, 12, 0);

    // Set/clear race on r4.
    step(1, 1, 32'hC1, 1, 4, 1, 4, 32'h44, 4, 0);
    step(0, 0, 0, 1, 4, 0, 0, 0, 4, 0);
    idle(3, 4, 0);

    // Reset mid-operation with two queued entries and pending bits.
    step(1, 1, 32'hD1, 1, 13, 1, 13, 32'h13, 13, 14);
    step(1, 2, 32'hD2, 1, 14, 1, 14, 32'h14, 13, 14);
    do_reset(5'd13, 5'd14);
    idle(4, 13, 14);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      if (i % 400 == 399) begin
        do_reset(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end else begin
        step(($urandom_range(0, 99) < 55),
             5'($urandom_range(0, 7)), $urandom(),
             ($urandom_range(0, 99) < 30), 5'($urandom_range(0, 7)),
             ($urandom_range(0, 99) < 40), 5'($urandom_range(0, 7)), $urandom(),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
    end
    idle(6, 0, 0);
    chk("scoreboard_drained", expq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Write-side initiator for the 32x32 register file's single write port. Merges single-cycle pipeline writeback (ALU/load) with long-latency multiply/divide results. Pipeline writes always take the port. Multdiv results are held in a small FIFO and drained into idle writeback slots. A per-register pending scoreboard is exposed to decode so it can stall on read-after-write (RAW) hazards against in-flight multdiv destinations.

## Interface
- DEPTH, 2, multdiv result FIFO depth; power of two, ≥2.
- clock  in  1  rising-edge clock.
- ctrl_reset  in  1  asynchronous, active-high reset.
- pipe_valid  in  1  writeback stage holds a result this cycle.
- pipe_rd  in  5  pipeline destination register.
- pipe_data  in  32  pipeline result.
- md_issue  in  1  multdiv operation launched this cycle.
- md_issue_rd  in  5  destination of the launched multdiv.
- md_valid  in  1  multdiv result available.
- md_rd  in  5  multdiv result destination.
- md_data  in  32  multdiv result.
- md_ready  out  1  FIFO not full; combinational.
- query_a, query_b  in  5  decode source-register queries.
- busy_a, busy_b  out  1  queried register has a pending multdiv write; combinational.
- err_overflow  out  1  sticky: a result arrived while the FIFO was full.
- ctrl_writeEnable  out  1  registered write enable to the register file.
- ctrl_writeReg  out  5  registered write address.
- data_writeReg  out  32  registered write data.

## Operation
- Writeback source selection, evaluated every cycle. First matching rule wins:
  - pipe_valid=1 and pipe_rd≠0: issue the pipeline write.
  - FIFO non-empty: pop the head and issue it.
  - Otherwise: write enable 0. Address and data hold their previous values.
- pipe_valid=1 with pipe_rd=0 is an idle slot, so the FIFO may drain in that cycle.
- FIFO push:
  - Condition: md_valid=1, md_ready=1 and md_rd≠0.
  - md_rd=0 results are discarded without a push.
- md_ready = !full, computed from the start-of-cycle occupancy. A pop in the same cycle does not free a slot for a push.
- Overflow: md_valid=1 while full means the result is dropped and err_overflow is set. err_overflow is cleared only by reset.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty are detected from a separate occupancy count, 0..DEPTH.
- Pending scoreboard (32 bits):
  - Set: md_issue=1 with md_issue_rd≠0 sets bit md_issue_rd.
  - Clear: a FIFO entry issued to the write port clears bit rd.
  - Set and clear of the same bit in one cycle: set wins.
  - Pipeline writes never modify the scoreboard.
- busy_x = pending[query_x] when query_x≠0; busy_x is always 0 when query_x=0.
- FIFO order is strictly preserved: first-in, first-out.

## Timing
- Pipeline result in cycle N → ctrl_writeEnable high in cycle N+1. One-cycle latency, no stall.
- Multdiv result pushed in cycle N, FIFO previously empty, no pipe write in N+1 → write in cycle N+2.
- Each pipeline write in the drain cycle delays the FIFO drain by one cycle. Starvation is the pipeline's responsibility.
- Scoreboard bit cleared at the edge that registers the write. busy deasserts in the same cycle ctrl_writeEnable asserts for that register.
- Reset values (asynchronous, immediate):
  - ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0.
  - FIFO empty, so md_ready=1.
  - Scoreboard cleared, so busy_a=busy_b=0.
  - err_overflow=0.
- Reset mid-drain discards all FIFO contents and pending bits. No partial write is emitted.

## Test plan
- Pipeline only: pipe_valid=1, rd=5, data=0x1234 in cycle 3 → writeEnable=1, writeReg=5, data=0x1234 in cycle 4; rd=0 → no write.
- Multdiv to idle port:
  - md_issue with rd=7 → busy for query 7 = 1.
  - md_valid with rd=7, data=0xDEAD in cycle 10, pipe idle → write r7=0xDEAD in cycle 12; busy=0 in cycle 12.
- Contention: pipeline writes every cycle while 2 multdiv results are queued (r8=1, r9=2) → FIFO holds both with md_ready=0. Pipeline then idles two cycles → r8 then r9 written in order.
- Overflow: FIFO full (DEPTH=2) and md_valid=1 → result dropped, err_overflow=1 and stays 1 until reset.
- Set/clear race: md_issue rd=4 in the same cycle a queued r4 result drains → r4 written, busy for query 4 stays 1.
- Reset mid-operation: assert ctrl_reset with 2 entries queued and pending bits set → all outputs 0, md_ready=1, no write after release.
